// File: rtl/pixel_pkg.sv
// pixel_pkg: shared widths, depths and reader state encoding for the pixel RAM reader.
package pixel_pkg;
   localparam int ADDR_W     = 18;
   localparam int PIX_W      = 24;
   localparam int MEM_DEPTH  = 4096;
   localparam int MEM_AW     = $clog2(MEM_DEPTH);
   localparam int CNT_W      = 13;
   localparam int FIFO_DEPTH = 4;
   localparam int FCNT_W     = $clog2(FIFO_DEPTH) + 1;
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FINISH} state_t;
endpackage

// File: rtl/pix_fifo.sv
// pix_fifo: show-ahead synchronous FIFO with occupancy count.
//  i_ck/i_rst_n : clock, async active-low reset (storage cleared so head reads 0)
//  i_push/i_data: write side; i_pop: consume head
//  o_data/o_valid: head entry and non-empty flag; o_count: occupancy 0..DEPTH
module pix_fifo #(
   parameter int W     = 24,
   parameter int DEPTH = 4
) (
   input  logic                     i_ck,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [W-1:0]             i_data,
   input  logic                     i_pop,
   output logic [W-1:0]             o_data,
   output logic                     o_valid,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [CW-1:0] r_count;
   logic          w_push, w_pop;
   // a pop frees the slot this cycle, so push at full is fine when popping
   assign w_pop   = i_pop & (r_count != '0);
   assign w_push  = i_push & ((r_count != CW'(DEPTH)) | w_pop);
   assign o_data  = r_mem[r_rd];
   assign o_valid = r_count != '0;
   assign o_count = r_count;
   always_ff @(posedge i_ck or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_pop) r_rd <= r_rd + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
endmodule

// File: rtl/ram_pixel_reader.sv
// ram_pixel_reader: fetches a run of pixels from the pixel RAM and streams them over valid/ready.
//  i_ck/i_rst_n           : clock, async active-low reset
//  i_start/i_base_addr/i_pix_cnt : run request (sampled in IDLE), first word, length 0..4096
//  o_busy/o_done          : run in progress / one-cycle completion pulse
//  o_a/o_oe/o_we/i_q      : RAM port (registered address, read data valid next edge)
//  o_pix_data/o_pix_valid/i_pix_ready/o_pix_last : output stream
//  o_cksum                : running sum of streamed pixels, only with PIXEL_READER_CKSUM_EN
module ram_pixel_reader
   import pixel_pkg::*;
(
   input  logic              i_ck,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [CNT_W-1:0]  i_pix_cnt,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_a,
   output logic              o_oe,
   output logic              o_we,
   input  logic [PIX_W-1:0]  i_q,
   output logic [PIX_W-1:0]  o_pix_data,
   output logic              o_pix_valid,
   input  logic              i_pix_ready,
   output logic              o_pix_last
`ifdef PIXEL_READER_CKSUM_EN
   ,output logic [PIX_W-1:0] o_cksum
`endif
);
   state_t             r_state, w_next;
   logic [CNT_W-1:0]   r_cnt, r_issued, r_popped, w_idx;
   logic [MEM_AW-1:0]  r_off, w_off;
   logic [ADDR_W-1:0]  r_a;
   logic               r_inflight;
   logic [FCNT_W-1:0]  w_fifo_cnt, w_fill;
   logic               w_start, w_issue, w_hs;
   pix_fifo #(.W(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_ck    (i_ck),
      .i_rst_n (i_rst_n),
      .i_push  (r_inflight),
      .i_data  (i_q),
      .i_pop   (w_hs),
      .o_data  (o_pix_data),
      .o_valid (o_pix_valid),
      .o_count (w_fifo_cnt)
   );
   assign w_start    = (r_state == S_IDLE) & i_start;
   // words already in the FIFO plus the one the RAM is returning must leave room
   assign w_fill     = w_fifo_cnt + FCNT_W'(r_inflight);
   assign w_issue    = (w_start & (i_pix_cnt != '0)) |
                       ((r_state == S_FETCH) & (r_issued < r_cnt) & (w_fill < FCNT_W'(FIFO_DEPTH)));
   assign w_off      = w_start ? i_base_addr[MEM_AW-1:0] : r_off;
   assign w_idx      = w_start ? '0 : r_issued;
   assign w_hs       = o_pix_valid & i_pix_ready;
   assign o_pix_last = o_pix_valid & (r_popped == r_cnt - 1'b1);
   assign o_a        = r_a;
   always_comb begin
      w_next = r_state;
      o_busy = r_state != S_IDLE;
      o_done = r_state == S_FINISH;
      o_oe   = (r_state == S_FETCH) | (r_state == S_DRAIN);
      o_we   = 1'b0;
      case (r_state)
         S_IDLE:  if (i_start) w_next = (i_pix_cnt == '0) ? S_FINISH : S_FETCH;
         S_FETCH: if (r_issued == r_cnt) w_next = S_DRAIN;
         S_DRAIN: if (w_hs & o_pix_last) w_next = S_FINISH;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge i_ck or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_issued   <= '0;
         r_popped   <= '0;
         r_off      <= '0;
         r_a        <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_inflight <= w_issue;
         if (w_start) begin
            r_cnt    <= i_pix_cnt;
            r_issued <= '0;
            r_popped <= '0;
         end
         if (w_issue) begin
            r_a      <= ADDR_W'(w_off);
            r_off    <= w_off + 1'b1;
            r_issued <= w_idx + 1'b1;
         end
         if (w_hs) r_popped <= r_popped + 1'b1;
      end
   end
`ifdef PIXEL_READER_CKSUM_EN
   logic [PIX_W-1:0] r_cksum;
   assign o_cksum = r_cksum;
   always_ff @(posedge i_ck or negedge i_rst_n) begin
      if (!i_rst_n) r_cksum <= '0;
      else if (w_start) r_cksum <= '0;
      else if (w_hs) r_cksum <= r_cksum + o_pix_data;
   end
`endif
endmodule

// File: tb/tb_ram_pixel_reader.sv
// tb_ram_pixel_reader: scoreboard bench with a behavioural RAM and randomized runs.
module tb_ram_pixel_reader;
   import pixel_pkg::*;
   logic              ck = 1'b0, rst_n = 1'b0, start = 1'b0, pix_ready = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [CNT_W-1:0]  pix_cnt = '0;
   logic              busy, done, oe, we, pix_valid, pix_last;
   logic [ADDR_W-1:0] a;
   logic [PIX_W-1:0]  q = '0, pix_data;
   logic [PIX_W-1:0]  sum_model = '0;
`ifdef PIXEL_READER_CKSUM_EN
   logic [PIX_W-1:0]  cksum;
`endif
   typedef struct {logic [PIX_W-1:0] d; logic l;} exp_t;
   exp_t              exp_q[$];
   exp_t              e;
   logic [PIX_W-1:0]  mem [MEM_DEPTH];
   int                checks = 0, errors = 0, done_seen = 0, hs_cnt = 0, mode = 0;
   bit                exp_done = 0, oe_seen = 0, valid_seen = 0;

   ram_pixel_reader dut (
      .i_ck(ck), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base_addr), .i_pix_cnt(pix_cnt),
      .o_busy(busy), .o_done(done), .o_a(a), .o_oe(oe), .o_we(we), .i_q(q),
      .o_pix_data(pix_data), .o_pix_valid(pix_valid), .i_pix_ready(pix_ready), .o_pix_last(pix_last)
`ifdef PIXEL_READER_CKSUM_EN
      , .o_cksum(cksum)
`endif
   );

   always #5 ck = ~ck;

   // RAM: latches the address on the falling edge, data ready before the next rising edge
   always @(negedge ck) q <= mem[a[MEM_AW-1:0]];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   initial forever begin
      @(posedge ck);
      #1 pix_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom & 1) : 1'b0;
   end

   // monitor: every handshake pops the scoreboard; done must follow the last pixel by one cycle
   always @(negedge ck) begin
      if (rst_n) begin
         if (exp_done) chk("done_after_last", done, 1);
         exp_done = 0;
         if (done) begin
            done_seen++;
`ifdef PIXEL_READER_CKSUM_EN
            chk("cksum_at_done", cksum, sum_model);
`endif
         end
         if (oe) oe_seen = 1;
         if (pix_valid) valid_seen = 1;
         if (pix_valid && pix_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pixel: got %0h expected none", pix_data);
            end else begin
               e = exp_q.pop_front();
               chk("pix_data", pix_data, e.d);
               chk("pix_last", pix_last, e.l);
               sum_model = sum_model + e.d;
               if (e.l) exp_done = 1;
            end
         end
      end
   end

   task automatic start_run(input logic [ADDR_W-1:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t x;
         x.d = mem[(int'(b) + i) % MEM_DEPTH];
         x.l = (i == n - 1);
         exp_q.push_back(x);
      end
      done_seen = 0;
      hs_cnt = 0;
      oe_seen = 0;
      valid_seen = 0;
      sum_model = '0;
      @(posedge ck);
      #1 start = 1'b1; base_addr = b; pix_cnt = CNT_W'(n);
      @(posedge ck);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int k = 0;
      while (done_seen == 0 && k < limit) begin
         @(posedge ck);
         k++;
      end
      checks++;
      if (done_seen == 0) begin
         errors++;
         $display("FAIL done_timeout: got no done expected done within %0d cycles", limit);
      end
      repeat (3) @(posedge ck);
      #1;
      chk("done_pulses", done_seen, 1);
      chk("queue_drained", exp_q.size(), 0);
      chk("busy_idle", busy, 0);
      chk("we_zero", we, 0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_oe", oe, 0);
      chk("rst_we", we, 0);
      chk("rst_valid", pix_valid, 0);
      chk("rst_last", pix_last, 0);
      chk("rst_a", a, 0);
      chk("rst_data", pix_data, 0);
`ifdef PIXEL_READER_CKSUM_EN
      chk("rst_cksum", cksum, 0);
`endif
   endtask

   initial begin
      int prev, issues, k;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] = PIX_W'($urandom);
      repeat (3) @(posedge ck);
      @(negedge ck);
      chk_reset_outputs();
      @(posedge ck);
      #1 rst_n = 1'b1;

      // straight run from word 0
      mode = 0;
      start_run(0, 8);
      for (int i = 0; i < 8; i++) begin
         @(negedge ck);
         chk("addr_seq", a, i);
         if (i == 0) chk("first_valid_low", pix_valid, 0);
         if (i == 1) chk("first_valid_high", pix_valid, 1);
      end
      wait_done(100);

      // consumer stalled: prefetch fills the FIFO then stops
      mode = 2;
      start_run(100, 10);
      prev = -1;
      issues = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge ck);
         if (int'(a) != prev) issues++;
         prev = int'(a);
      end
      chk("stall_issues", issues, FIFO_DEPTH);
      chk("stall_addr", a, 100 + FIFO_DEPTH - 1);
      chk("stall_valid", pix_valid, 1);
      chk("stall_oe", oe, 1);
      @(posedge ck);
      #1 start = 1'b1; base_addr = 7; pix_cnt = 2;
      @(posedge ck);
      #1 start = 1'b0;
      mode = 0;
      wait_done(200);

      // address wrap at the top of the RAM
      start_run(4094, 4);
      for (int i = 0; i < 4; i++) begin
         @(negedge ck);
         chk("wrap_addr", a, (4094 + i) % MEM_DEPTH);
      end
      wait_done(100);

      // empty run
      start_run(300, 0);
      repeat (4) @(negedge ck);
      chk("zero_done", done_seen, 1);
      chk("zero_oe", oe_seen, 0);
      chk("zero_valid", valid_seen, 0);
      wait_done(10);

      // reset in the middle of a run
      start_run(500, 10);
      k = 0;
      while (hs_cnt < 3 && k < 100) begin
         @(posedge ck);
         k++;
      end
      checks++;
      if (hs_cnt < 3) begin
         errors++;
         $display("FAIL midrun_pixels: got %0d expected 3", hs_cnt);
      end
      #1 rst_n = 1'b0;
      #1;
      exp_q.delete();
      exp_done = 0;
      chk_reset_outputs();
      repeat (2) @(posedge ck);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge ck);
      #1 chk("no_done_after_reset", done_seen, 0);
      start_run(1234, 6);
      wait_done(100);

`ifdef PIXEL_READER_CKSUM_EN
      mem[200] = 24'h000001;
      mem[201] = 24'h000002;
      mem[202] = 24'hFFFFFF;
      start_run(200, 3);
      wait_done(100);
      chk("cksum_final", cksum, 24'h000002);
`endif

      // random runs with random back-pressure, full 18-bit bases
      mode = 1;
      for (int r = 0; r < 8; r++) begin
         start_run(ADDR_W'($urandom), $urandom_range(1, 40));
         wait_done(2000);
      end

      // maximum length run
      mode = 0;
      start_run(4000, MEM_DEPTH);
      wait_done(6000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
